// File: rtl/flag_pkg.sv
// Shared constants and helpers for the flag register / branch-condition unit.
package flag_pkg;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_EQUAL = 1;
    localparam int FLAG_GT    = 2;
    localparam int FLAG_LT    = 3;

    // Condition code layout is {TEST, INVERT, SEL[sel_w-1:0]}
    function automatic int cond_inv_bit(input int sel_w);
        return sel_w;
    endfunction

    function automatic int cond_test_bit(input int sel_w);
        return sel_w + 1;
    endfunction

    function automatic int cond_width(input int num_flags);
        return $clog2(num_flags) + 2;
    endfunction

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational condition evaluation: result = !TEST | (INVERT ^ FLAGS[SEL]).
module flag_cond_eval
    import flag_pkg::*;
#(
    parameter int NUM_FLAGS = 4,
    parameter int SEL_W     = $clog2(NUM_FLAGS)
) (
    input  logic [NUM_FLAGS-1:0] flags,
    input  logic [SEL_W+1:0]     cond,
    output logic                 result
);

    localparam int TEST_BIT = cond_test_bit(SEL_W);
    localparam int INV_BIT  = cond_inv_bit(SEL_W);

    logic [SEL_W-1:0] sel_s;
    logic             selected_s;

    assign sel_s = cond[SEL_W-1:0];

    // Out-of-range selects read as a cleared flag
    always_comb begin
        selected_s = 1'b0;
        if (int'(sel_s) < NUM_FLAGS) begin
            selected_s = flags[sel_s];
        end else begin
            selected_s = 1'b0;
        end
    end

    assign result = ~cond[TEST_BIT] | (cond[INV_BIT] ^ selected_s);

endmodule

// File: rtl/flag_unit.sv
// Flag register with LIFO save/restore stack and a registered branch-condition result.
module flag_unit
    import flag_pkg::*;
#(
    parameter int NUM_FLAGS   = 4,
    parameter int STACK_DEPTH = 4,
    parameter int FORWARD     = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_FLAGS-1:0]                flags_in,
    input  logic                                flags_we,
    input  logic [cond_width(NUM_FLAGS)-1:0]    cond,
    input  logic                                cond_valid,
    input  logic                                push,
    input  logic                                pop,
    output logic [NUM_FLAGS-1:0]                flags_out,
    output logic                                take,
    output logic                                take_valid,
    output logic                                stack_full,
    output logic                                stack_empty,
    output logic                                stack_err
);

    localparam int SEL_W = $clog2(NUM_FLAGS);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [NUM_FLAGS-1:0] stack_mem_r [STACK_DEPTH];
    logic [NUM_FLAGS-1:0] flags_r;
    logic [SP_W-1:0]      sp_r;
    logic                 full_r;
    logic                 empty_r;
    logic                 err_r;
    logic                 take_r;
    logic                 take_valid_r;

    logic                 push_ok_s;
    logic                 pop_ok_s;
    logic                 err_event_s;
    logic [SP_W-1:0]      sp_next_s;
    logic [IDX_W-1:0]     push_idx_s;
    logic [IDX_W-1:0]     pop_idx_s;
    logic [NUM_FLAGS-1:0] next_flags_s;
    logic [NUM_FLAGS-1:0] eval_flags_s;
    logic                 result_s;

    // A simultaneous PUSH and POP cancels both and is reported as an error
    assign push_ok_s   = push & ~pop & ~full_r;
    assign pop_ok_s    = pop & ~push & ~empty_r;
    assign err_event_s = (push & pop) | (push & ~pop & full_r) | (pop & ~push & empty_r);

    // Stack pointer update and memory indices
    always_comb begin
        sp_next_s  = sp_r;
        push_idx_s = IDX_W'(sp_r);
        pop_idx_s  = IDX_W'(sp_r - SP_W'(1));
        if (push_ok_s) begin
            sp_next_s = sp_r + SP_W'(1);
        end else if (pop_ok_s) begin
            sp_next_s = sp_r - SP_W'(1);
        end else begin
            sp_next_s = sp_r;
        end
    end

    // Next flag value: restore beats ALU load beats hold
    always_comb begin
        next_flags_s = flags_r;
        if (pop_ok_s) begin
            next_flags_s = stack_mem_r[pop_idx_s];
        end else if (flags_we) begin
            next_flags_s = flags_in;
        end else begin
            next_flags_s = flags_r;
        end
    end

    assign eval_flags_s = (FORWARD != 0) ? next_flags_s : flags_r;

    flag_cond_eval #(
        .NUM_FLAGS (NUM_FLAGS),
        .SEL_W     (SEL_W)
    ) u_cond_eval (
        .flags  (eval_flags_s),
        .cond   (cond),
        .result (result_s)
    );

    // Stack storage; contents need no reset because sp gates every read
    always_ff @(posedge clk) begin
        if (rst_n && push_ok_s) begin
            stack_mem_r[push_idx_s] <= flags_r;
        end
    end

    // Flag register, stack pointer, status and take result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_r      <= '0;
            sp_r         <= '0;
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            err_r        <= 1'b0;
            take_r       <= 1'b0;
            take_valid_r <= 1'b0;
        end else begin
            flags_r      <= next_flags_s;
            sp_r         <= sp_next_s;
            full_r       <= (sp_next_s == SP_W'(STACK_DEPTH));
            empty_r      <= (sp_next_s == SP_W'(0));
            err_r        <= err_r | err_event_s;
            take_valid_r <= cond_valid;
            if (cond_valid) begin
                take_r <= result_s;
            end
        end
    end

    assign flags_out   = flags_r;
    assign take        = take_r;
    assign take_valid  = take_valid_r;
    assign stack_full  = full_r;
    assign stack_empty = empty_r;
    assign stack_err   = err_r;

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: a forwarding and a non-forwarding instance share stimulus.
module tb_flag_unit;

    typedef struct packed {
        logic [3:0] flags;
        logic       full;
        logic       empty;
        logic       err;
    } st_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] flags_in;
    logic       flags_we;
    logic [3:0] cond;
    logic       cond_valid;
    logic       push;
    logic       pop;

    logic [3:0] flags_out, flags_out_nf;
    logic       take, take_nf;
    logic       take_valid, take_valid_nf;
    logic       stack_full, stack_full_nf;
    logic       stack_empty, stack_empty_nf;
    logic       stack_err, stack_err_nf;

    st_t  state_q[$];
    logic take_q[$];
    logic take_nf_q[$];

    int   n_compared   = 0;
    int   n_mismatched = 0;
    logic done         = 1'b0;

    always #5 clk = ~clk;

    flag_unit #(.NUM_FLAGS(4), .STACK_DEPTH(4), .FORWARD(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flags_in(flags_in), .flags_we(flags_we),
        .cond(cond), .cond_valid(cond_valid), .push(push), .pop(pop),
        .flags_out(flags_out), .take(take), .take_valid(take_valid),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
    );

    flag_unit #(.NUM_FLAGS(4), .STACK_DEPTH(4), .FORWARD(0)) u_dut_nf (
        .clk(clk), .rst_n(rst_n), .flags_in(flags_in), .flags_we(flags_we),
        .cond(cond), .cond_valid(cond_valid), .push(push), .pop(pop),
        .flags_out(flags_out_nf), .take(take_nf), .take_valid(take_valid_nf),
        .stack_full(stack_full_nf), .stack_empty(stack_empty_nf), .stack_err(stack_err_nf)
    );

    function automatic void check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_compared = n_compared + 1;
        if (act !== exp) begin
            n_mismatched = n_mismatched + 1;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compare every post-edge state and every presented TAKE against the queues
    always @(negedge clk) begin
        st_t  e;
        logic t;
        if (state_q.size() > 0) begin
            e = state_q.pop_front();
            check("flags_out",   flags_out,           e.flags);
            check("stack_full",  {3'b000, stack_full},  {3'b000, e.full});
            check("stack_empty", {3'b000, stack_empty}, {3'b000, e.empty});
            check("stack_err",   {3'b000, stack_err},   {3'b000, e.err});
        end
        if (take_valid === 1'b1) begin
            if (take_q.size() == 0) begin
                check("take_valid_unexpected", {3'b000, take_valid}, 4'b0000);
            end else begin
                t = take_q.pop_front();
                check("take_fwd", {3'b000, take}, {3'b000, t});
            end
        end else if (take_q.size() > 0) begin
            t = take_q.pop_front();
            check("take_valid_missing", {3'b000, take_valid}, 4'b0001);
        end
        if (take_valid_nf === 1'b1) begin
            if (take_nf_q.size() == 0) begin
                check("take_valid_nf_unexpected", {3'b000, take_valid_nf}, 4'b0000);
            end else begin
                t = take_nf_q.pop_front();
                check("take_nofwd", {3'b000, take_nf}, {3'b000, t});
            end
        end else if (take_nf_q.size() > 0) begin
            t = take_nf_q.pop_front();
            check("take_valid_nf_missing", {3'b000, take_valid_nf}, 4'b0001);
        end
        if (done) begin
            check("leftover_expectations",
                  4'(state_q.size() + take_q.size() + take_nf_q.size()), 4'b0000);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    // Apply one cycle of inputs; record what the edge must produce
    task automatic step(input logic rn, input logic we, input logic [3:0] fin,
                        input logic cv, input logic [3:0] cnd, input logic pu, input logic po,
                        input logic et, input logic etn,
                        input logic [3:0] ef, input logic efu, input logic eem, input logic eer);
        st_t s;
        rst_n = rn; flags_we = we; flags_in = fin;
        cond_valid = cv; cond = cnd; push = pu; pop = po;
        @(posedge clk);
        s.flags = ef; s.full = efu; s.empty = eem; s.err = eer;
        state_q.push_back(s);
        if (cv && rn) begin
            take_q.push_back(et);
            take_nf_q.push_back(etn);
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flags_in = 4'b0000; flags_we = 1'b0; cond = 4'b0000;
        cond_valid = 1'b0; push = 1'b0; pop = 1'b0;
        //    rn we fin     cv cond     pu po  et etn  flags   fu em er
        step(0, 0, 4'b0000, 0, 4'b0000, 0, 0,  0, 0,  4'b0000, 0, 1, 0);
        step(0, 0, 4'b0000, 1, 4'b0000, 0, 0,  0, 0,  4'b0000, 0, 1, 0);
        // Condition function against the equal flag
        step(1, 1, 4'b0010, 0, 4'b0000, 0, 0,  0, 0,  4'b0010, 0, 1, 0);
        step(1, 0, 4'b0000, 1, 4'b1001, 0, 0,  1, 1,  4'b0010, 0, 1, 0);
        step(1, 0, 4'b0000, 1, 4'b1101, 0, 0,  0, 0,  4'b0010, 0, 1, 0);
        step(1, 0, 4'b0000, 1, 4'b0111, 0, 0,  1, 1,  4'b0010, 0, 1, 0);
        step(1, 0, 4'b0000, 1, 4'b1110, 0, 0,  1, 1,  4'b0010, 0, 1, 0);
        // Forwarding: same-cycle load of the zero flag
        step(1, 1, 4'b0000, 0, 4'b0000, 0, 0,  0, 0,  4'b0000, 0, 1, 0);
        step(1, 1, 4'b0001, 1, 4'b1000, 0, 0,  1, 0,  4'b0001, 0, 1, 0);
        // Fill the stack, overflow, then drain
        step(1, 0, 4'b0000, 0, 4'b0000, 1, 0,  0, 0,  4'b0001, 0, 0, 0);
        step(1, 1, 4'b0010, 0, 4'b0000, 0, 0,  0, 0,  4'b0010, 0, 0, 0);
        step(1, 0, 4'b0000, 0, 4'b0000, 1, 0,  0, 0,  4'b0010, 0, 0, 0);
        step(1, 1, 4'b0100, 0, 4'b0000, 0, 0,  0, 0,  4'b0100, 0, 0, 0);
        step(1, 0, 4'b0000, 0, 4'b0000, 1, 0,  0, 0,  4'b0100, 0, 0, 0);
        step(1, 1, 4'b1000, 0, 4'b0000, 0, 0,  0, 0,  4'b1000, 0, 0, 0);
        step(1, 0, 4'b0000, 0, 4'b0000, 1, 0,  0, 0,  4'b1000, 1, 0, 0);
        step(1, 0, 4'b0000, 0, 4'b0000, 1, 0,  0, 0,  4'b1000, 1, 0, 1);
        step(1, 0, 4'b0000, 0, 4'b0000, 0, 1,  0, 0,  4'b1000, 0, 0, 1);
        step(1, 0, 4'b0000, 0, 4'b0000, 0, 1,  0, 0,  4'b0100, 0, 0, 1);
        step(1, 0, 4'b0000, 0, 4'b0000, 0, 1,  0, 0,  4'b0010, 0, 0, 1);
        step(1, 1, 4'b1111, 1, 4'b1000, 0, 1,  1, 0,  4'b0001, 0, 1, 1);
        // Reset, then underflow while an ALU load still lands
        step(0, 0, 4'b0000, 0, 4'b0000, 0, 0,  0, 0,  4'b0000, 0, 1, 0);
        step(1, 1, 4'b0101, 0, 4'b0000, 0, 0,  0, 0,  4'b0101, 0, 1, 0);
        step(1, 1, 4'b1110, 0, 4'b0000, 0, 1,  0, 0,  4'b1110, 0, 1, 1);
        step(1, 0, 4'b0000, 0, 4'b0000, 0, 1,  0, 0,  4'b1110, 0, 1, 1);
        // Push coinciding with a load saves the old value
        step(0, 0, 4'b0000, 1, 4'b1000, 0, 0,  0, 0,  4'b0000, 0, 1, 0);
        step(1, 1, 4'b0011, 0, 4'b0000, 0, 0,  0, 0,  4'b0011, 0, 1, 0);
        step(1, 1, 4'b1100, 0, 4'b0000, 1, 0,  0, 0,  4'b1100, 0, 0, 0);
        step(1, 0, 4'b0000, 1, 4'b1011, 0, 1,  0, 1,  4'b0011, 0, 1, 0);
        // PUSH and POP together leave sp alone
        step(1, 0, 4'b0000, 0, 4'b0000, 1, 0,  0, 0,  4'b0011, 0, 0, 0);
        step(1, 1, 4'b0110, 0, 4'b0000, 1, 1,  0, 0,  4'b0110, 0, 0, 1);
        step(1, 0, 4'b0000, 0, 4'b0000, 0, 1,  0, 0,  4'b0011, 0, 1, 1);
        step(1, 0, 4'b0000, 0, 4'b0000, 1, 0,  0, 0,  4'b0011, 0, 0, 1);
        step(1, 0, 4'b0000, 0, 4'b0000, 1, 0,  0, 0,  4'b0011, 0, 0, 1);
        // Mid-sequence reset discards the stack; a following POP underflows
        step(0, 1, 4'b1111, 1, 4'b0000, 0, 1,  0, 0,  4'b0000, 0, 1, 0);
        step(1, 0, 4'b0000, 0, 4'b0000, 0, 1,  0, 0,  4'b0000, 0, 1, 1);
        rst_n = 1'b1; flags_we = 1'b0; cond_valid = 1'b0; push = 1'b0; pop = 1'b0;
        @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
Parametrised flag register and branch-condition unit for the CPU datapath. Latches ALU status flags and evaluates a conditional-jump condition code against them, with a registered take/not-take result. Holds a small LIFO flag stack so interrupt and call sequences can save and restore flags. Sits between the ALU flag outputs and the program-counter load logic.

Parameters:
NUM_FLAGS, 4, number of status flags held (index 0 = zero, 1 = equal, 2 = greater-than, 3 = less-than); legal range 2..16
SEL_W, $clog2(NUM_FLAGS), flag-select field width (derived, not overridden)
STACK_DEPTH, 4, flag-stack entries; legal range 1..16
FORWARD, 1, 1 = a condition evaluated in the same cycle as a flag update sees the new value; 0 = it sees the old register value

Ports:
CLK  in  1  system clock, all state on rising edge
RST_N  in  1  reset, synchronous and active-low
FLAGS_IN  in  NUM_FLAGS  flag vector from the ALU
FLAGS_WE  in  1  load FLAGS_IN into the flag register
COND  in  SEL_W+2  condition code {TEST, INVERT, SEL[SEL_W-1:0]}
COND_VALID  in  1  evaluate COND this cycle
PUSH  in  1  save the current flag register onto the stack
POP  in  1  restore the flag register from the top of the stack
FLAGS_OUT  out  NUM_FLAGS  current flag register
TAKE  out  1  registered condition result
TAKE_VALID  out  1  TAKE is valid this cycle
STACK_FULL  out  1  stack holds STACK_DEPTH entries
STACK_EMPTY  out  1  stack holds 0 entries
STACK_ERR  out  1  sticky error: overflow, underflow, or PUSH and POP asserted together

Behaviour:
- Reset (RST_N low at a clock edge) has priority over all other inputs. It sets FLAGS_OUT=0, TAKE=0, TAKE_VALID=0, stack pointer=0, STACK_EMPTY=1, STACK_FULL=0 and STACK_ERR=0. Stack contents are don't-care after reset.
- Condition function: selected = FLAGS[SEL] if SEL < NUM_FLAGS, otherwise 0. result = !TEST | (INVERT ^ selected).
- Latency is 1 cycle. If COND_VALID is high in cycle n, TAKE and TAKE_VALID are valid in cycle n+1. TAKE_VALID is low whenever COND_VALID was low in the previous cycle. When TAKE_VALID is low, TAKE holds its last value.
- Evaluation source:
  - FORWARD=1: the evaluation uses next_flags, the value FLAGS_OUT will hold after this edge (this includes POP and FLAGS_WE effects).
  - FORWARD=0: the evaluation uses the current FLAGS_OUT.
- Flag register next value, in priority order:
  1. Valid POP loads the stack top.
  2. Otherwise FLAGS_WE loads FLAGS_IN.
  3. Otherwise the register holds its value.
  - A valid POP that coincides with FLAGS_WE discards FLAGS_WE.
- PUSH (POP low, stack not full): the pre-edge FLAGS_OUT is written to stack[sp] and sp is incremented. If FLAGS_WE is also high, the register takes FLAGS_IN in the same edge, and the stack still receives the old value.
- POP (PUSH low, stack not empty): sp is decremented and FLAGS_OUT takes stack[sp-1].
- Error cases:
  - PUSH when full: no stack change, STACK_ERR set. FLAGS_WE still applies.
  - POP when empty: no stack change, flag register follows FLAGS_WE/hold, STACK_ERR set.
  - PUSH and POP high together: both ignored, STACK_ERR set, FLAGS_WE still applies.
- STACK_ERR is cleared only by reset.
- STACK_FULL and STACK_EMPTY are registered and derived from sp: full when sp == STACK_DEPTH, empty when sp == 0.
- The stack pointer is SP_W = $clog2(STACK_DEPTH+1) bits and never wraps.
- Reset asserted mid-sequence (for example between PUSH and POP) discards all stack entries. A POP issued after reset is an underflow.

Decomposition:
- Package flag_pkg holds:
  - flag index constants FLAG_ZERO=0, FLAG_EQUAL=1, FLAG_GT=2, FLAG_LT=3;
  - condition field positions COND_TEST_BIT and COND_INV_BIT as functions of SEL_W;
  - helper function cond_width(num_flags).
- One combinational sub-module, flag_cond_eval (flags, cond -> result), instantiated once. Registering, forwarding mux and stack stay in flag_unit.

Test Plan (NUM_FLAGS=4, STACK_DEPTH=4, FORWARD=1 unless noted; COND written as TEST,INV,SEL):
1. Reset, then FLAGS_WE with FLAGS_IN=4'b0010 (equal). Next cycle COND=1,0,01 with COND_VALID -> one cycle later TAKE=1, TAKE_VALID=1. COND=1,1,01 -> TAKE=0. COND=0,x,xx -> TAKE=1.
2. FORWARD=1 vs FORWARD=0, with flags 4'b0000 and, in one cycle, FLAGS_WE with FLAGS_IN=4'b0001 plus COND=1,0,00 -> TAKE=1 for FORWARD=1 and TAKE=0 for FORWARD=0.
3. Push sequence: push 4'b0001, 4'b0010, 4'b0100, 4'b1000, loading each via FLAGS_WE before its PUSH. -> STACK_FULL=1. A fifth PUSH -> STACK_ERR=1 and sp stays 4. Four POPs -> FLAGS_OUT = 1000, 0100, 0010, 0001 in order, then STACK_EMPTY=1.
4. With flags 4'b0011, in one cycle PUSH together with FLAGS_WE and FLAGS_IN=4'b1100 -> FLAGS_OUT=1100. A later POP -> FLAGS_OUT=0011.
5. With STACK_EMPTY=1, POP -> STACK_ERR=1 and FLAGS_OUT unchanged. PUSH and POP together on a non-empty stack -> no sp change and STACK_ERR=1.
6. Assert RST_N=0 for one cycle with sp=2 and STACK_ERR=1 -> all outputs at reset values and STACK_EMPTY=1. An immediate POP -> underflow and STACK_ERR=1.
